// File: rtl/bin2bcd_3dig.sv
`default_nettype none
// ============================================================================
//  Module   : bin2bcd_3dig
//  Purpose  : Sequential binary-to-BCD converter using shift-and-add-3. It
//             converts one input bit per clock and feeds a three-digit
//             seven-segment scan decoder.
//             bcd_out = {hundreds, tens, units}.
//  Ports    : sys_clk  - system clock, rising edge
//             sys_rst  - synchronous active-high reset
//             bin_in   - unsigned value, captured on the accepting edge
//             start    - conversion request, ignored while busy
//             busy     - conversion in progress
//             done     - one-cycle pulse, first cycle the new result is valid
//             bcd_out  - three-digit BCD result, held between conversions
//             ovf      - value exceeded 999 (saturating build only)
//  Config   : BIN2BCD_SAT_EN - when defined, values above 999 saturate to
//             12'h999 with ovf=1. Otherwise the result is value mod 1000
//             and ovf is tied to 0.
//  Revision : 1.0 - initial release
// ============================================================================
module bin2bcd_3dig #(
    parameter int BIN_W = 10
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic [BIN_W-1:0] bin_in,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [11:0]      bcd_out,
    output logic             ovf
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_shift = 2'd1;
    localparam logic [1:0] c_st_load  = 2'd2;

    // Counter value during the final shift edge.
    localparam logic [3:0] c_last_cnt = 4'(BIN_W - 1);

    logic [1:0]       r_state;
    logic [BIN_W-1:0] r_shift;
    logic [15:0]      r_scratch;
    logic [3:0]       r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [11:0]      r_bcd;

    // Bits of the scratch word that survive the next left shift, after the
    // add-3 correction. The MSB of the thousands digit is shifted out, so
    // that digit is corrected in 3-bit arithmetic. Its low three bits match
    // those of the full 4-bit sum.
    logic [14:0]      w_adj;

    function automatic logic [3:0] f_add3(input logic [3:0] d);
        return (d >= 4'd5) ? (d + 4'd3) : d;
    endfunction

    always_comb begin
        w_adj          = '0;
        w_adj[3:0]     = f_add3(r_scratch[3:0]);
        w_adj[7:4]     = f_add3(r_scratch[7:4]);
        w_adj[11:8]    = f_add3(r_scratch[11:8]);
        w_adj[14:12]   = r_scratch[14:12]
                       + ((r_scratch[15:12] >= 4'd5) ? 3'd3 : 3'd0);
    end

`ifdef BIN2BCD_SAT_EN
    logic r_ovf;
`endif

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state   <= c_st_idle;
            r_shift   <= '0;
            r_scratch <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_bcd     <= 12'h000;
`ifdef BIN2BCD_SAT_EN
            r_ovf     <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_shift   <= bin_in;
                        r_scratch <= '0;
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= c_st_shift;
                    end
                end
                c_st_shift: begin
                    // {scratch, shift} <<= 1 after the digit correction.
                    r_scratch <= {w_adj, r_shift[BIN_W-1]};
                    r_shift   <= {r_shift[BIN_W-2:0], 1'b0};
                    r_cnt     <= r_cnt + 4'd1;
                    if (r_cnt == c_last_cnt) begin
                        r_state <= c_st_load;
                    end
                end
                c_st_load: begin
`ifdef BIN2BCD_SAT_EN
                    if (r_scratch[15:12] != 4'd0) begin
                        r_bcd <= 12'h999;
                        r_ovf <= 1'b1;
                    end else begin
                        r_bcd <= r_scratch[11:0];
                        r_ovf <= 1'b0;
                    end
`else
                    r_bcd   <= r_scratch[11:0];
`endif
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign bcd_out = r_bcd;
`ifdef BIN2BCD_SAT_EN
    assign ovf     = r_ovf;
`else
    assign ovf     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/bin2bcd_3dig.md
# bin2bcd_3dig

Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) that produces the 12-bit, three-digit BCD word consumed by the three-digit seven-segment scan decoder. It sits directly upstream of that decoder: bits [3:0] carry the units digit, [7:4] the tens digit and [11:8] the hundreds digit, so the display reads decimal instead of hex. A start/busy/done handshake lets a counter or sampler request a conversion, and the result is held stable between conversions.

## Interface
- `BIN_W`, default 10: width of the binary input. Legal range 4..13; the internal scratch register always holds 4 BCD digits.
- `sys_clk` in, 1: system clock; all state updates on the rising edge.
- `sys_rst` in, 1: reset, synchronous, active-high.
- `bin_in` in, `BIN_W`: unsigned value to convert; sampled only on the accepting edge.
- `start` in, 1: conversion request; sampled every edge.
- `busy` out, 1: high while a conversion is in progress.
- `done` out, 1: one-cycle pulse, coincident with the first cycle in which `bcd_out` holds the new result.
- `bcd_out` out, 12: {hundreds, tens, units} BCD; held between conversions.
- `ovf` out, 1: overflow flag for the last result (see Configuration); updates together with `bcd_out`.

## Operation
- States: IDLE, SHIFT, LOAD.
- IDLE: if `start`=1 on an edge, capture `bin_in` into the shift register, clear the 16-bit BCD scratch and the bit counter, set `busy`=1, and go to SHIFT. Otherwise stay in IDLE.
- SHIFT: on each edge, add 3 to every scratch digit that is >=5, then shift {scratch, shift register} left by 1 and increment the counter. After the `BIN_W`-th shift, go to LOAD.
- LOAD: on one edge, write `bcd_out` and `ovf` from the scratch (as described under Configuration), pulse `done`=1, set `busy`=0, and return to IDLE.
- `start` is ignored while `busy`=1; it is neither queued nor latched.
- `bin_in` may change freely after the accepting edge without affecting the running conversion.
- Arithmetic: add-3 uses 4-bit digits with no carry between digits. The thousands digit exists only in the scratch register.
- Reset (any state, including mid-conversion):
  - `bcd_out`=12'h000, `ovf`=0, `busy`=0, `done`=0.
  - State returns to IDLE and the scratch and counter are cleared.
  - An aborted conversion never produces `done`.
  - If reset and `start` are asserted together, reset wins.

## Timing
- Accepting edge E0: `busy` rises after E0.
- Shift edges: E1..E`BIN_W`.
- LOAD edge: E`BIN_W`+1. After this edge, `done`=1 for exactly one cycle, `busy`=0, and `bcd_out`/`ovf` are valid.
- Latency from the accepting edge to valid result is `BIN_W`+1 edges (11 for the default).
- `start`=1 during the cycle in which `done`=1 is accepted, because the block is already in IDLE. Back-to-back throughput is therefore one conversion every `BIN_W`+2 edges.
- `bcd_out` changes only on the LOAD edge or on reset. The downstream decoder may sample it on any cycle.

## Configuration
- Macro: `BIN2BCD_SAT_EN`.
- Defined:
  - If the thousands digit is non-zero (input >999), `bcd_out`=12'h999 and `ovf`=1.
  - Otherwise `bcd_out` holds the low three digits and `ovf`=0.
- Undefined:
  - `bcd_out` is always the low three BCD digits, i.e. value mod 1000.
  - `ovf` is constant 0, and the saturation comparator is not synthesised.
- When `BIN_W`<=9 the input cannot exceed 999 (max 511), so the macro has no visible effect.

## Test plan
- Reset, then `bin_in`=0 with `start` for one cycle -> `busy` high for 11 cycles, `done` pulse after E11, `bcd_out`=12'h000, `ovf`=0.
- `bin_in`=999 -> `bcd_out`=12'h999 exactly at the `done` pulse (E11), with `ovf`=0.
- `bin_in`=1023 -> with `BIN2BCD_SAT_EN`: `bcd_out`=12'h999, `ovf`=1; without: `bcd_out`=12'h023, `ovf`=0.
- Start 123, pulse `start` again at E3 with `bin_in`=456 -> second request ignored, result 12'h123, single `done`. Then assert `start` in the `done` cycle with 456 -> 12'h456 exactly 12 edges after the first `done`.
- Start 500, assert `sys_rst` at E5 -> no `done`, `busy`=0, `bcd_out`=12'h000 after the reset edge. A following conversion of 42 -> 12'h042.
- Sweep 0..999 with self-check against a decimal reference model -> every result matches, and `done` occurs exactly once per accepted `start`.
